fifo_flush_reader: RTL
======================

// Module: fifo_flush_reader
// PURPOSE
//  Read-side initiator for the nibble flush FIFO: watches data-available/empty, runs the 3-cycle
//  flush handshake, captures the packed 32-bit word (8 nibbles, unused slots padded 4'hC), and
//  replays the valid nibbles one per cycle on a valid/ready stream. Sits between the FIFO and the nibble consumer.
// PARAMETERS
//  IDLE_TIMEOUT  16  cycles FIFO non-empty without data_avail before a partial flush is forced (0 = never)
//  TO_W          5   width of the timeout counter; must hold IDLE_TIMEOUT
// PORTS
//  clk                 in   1   clock, all logic on rising edge
//  reset               in   1   asynchronous, active-low reset
//  fifo_data_avail_i   in   1   FIFO holds >=4 nibbles
//  fifo_empty_i        in   1   FIFO empty
//  fifo_rd_data_i      in   32  packed flush word; slot k = bits [4k+3:4k]
//  fifo_flush_o        out  1   flush request to FIFO
//  nib_valid_o         out  1   nibble output valid
//  nib_data_o          out  4   nibble output data
//  nib_last_o          out  1   last nibble of current flush word
//  nib_ready_i         in   1   consumer accepts nibble
//  busy_o              out  1   high in any state except IDLE
// BEHAVIOUR
//  - Reset: fifo_flush_o=0, nib_valid_o=0, nib_data_o=0, nib_last_o=0, busy_o=0, state IDLE, timeout=0.
//    Reset mid-flush drops fifo_flush_o immediately (async) and aborts; a partly drained word is discarded.
//  - States: IDLE -> F1 -> F2 -> F3 -> DRAIN -> GAP -> IDLE.
//  - IDLE: start when fifo_data_avail_i=1, or when !fifo_empty_i && timeout==IDLE_TIMEOUT (IDLE_TIMEOUT!=0).
//    timeout increments each IDLE cycle with !fifo_empty_i && !fifo_data_avail_i, saturates, clears otherwise and on start.
//  - F1,F2,F3: fifo_flush_o=1 (registered, exactly 3 consecutive cycles). At the end of F3 latch fifo_rd_data_i
//    into word_q; compute count = index of first slot equal to 4'hC (8 if none). 4'hC is reserved; producers never write it.
//  - F3 -> DRAIN if count>0; F3 -> GAP directly if count==0 (empty flush, no nibble output).
//  - DRAIN: nib_valid_o=1, nib_data_o=word_q slot idx (idx starts 0, low nibble first), nib_last_o=(idx==count-1).
//    On valid&&ready: idx++; after the last accept -> GAP. Without ready, data/last held stable, no advance.
//  - GAP: fifo_flush_o=0 for exactly 1 cycle (lets FIFO close the flush and clear data_avail); then IDLE.
//  - Inputs changing during F1..GAP are ignored; fifo_data_avail_i is only sampled in IDLE.
//  - Latency: start decision -> first nib_valid_o = 4 cycles; back-to-back words min period = count+5 cycles.
//  - Slots after the first 4'hC are ignored even if non-pad.
// CONFIGURATION
//  FLUSH_READER_STATS_EN defined: extra outputs stat_words_o[15:0] (completed flushes, count>0),
//   stat_nibbles_o[15:0] (accepted nibbles), stat_empty_o[7:0] (flushes with count==0), stat_timeout_o[7:0]
//   (timeout-forced starts); all wrap, reset to 0, update on the cycle of the event.
//  Not defined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  fifo_flush_pkg: PAD_NIBBLE=4'hC, NIBBLES_PER_WORD=8, FLUSH_HOLD=3, state encoding localparams.
//  Sub-module flush_nibble_serializer: holds word_q/count/idx, drives nib_* and done; control FSM stays in top.
// TESTING
//  1 reset low mid-F2 -> fifo_flush_o=0 same cycle; after release busy_o=0, nib_valid_o=0.
//  2 avail=1, word 32'hCCC54321, ready=1 -> flush 3 cycles, nibbles 1,2,3,4,5, last on 5, GAP, IDLE.
//  3 word 32'h87654321, ready toggling 1/0 -> 8 nibbles 1..8 in order, each held while ready=0, last on 8.
//  4 empty=0, avail=0 for 16 cycles, word 32'hCCCCCC0A -> forced flush, nibbles A,0; stat_timeout_o=1 with _EN.
//  5 word 32'hCCCCCCCC -> no nib_valid_o, F3->GAP; stat_empty_o increments with _EN.
//  6 avail held 1 across two words -> second F1 no earlier than 1 cycle after GAP; flush low in GAP.

Source files
------------

// File: rtl/fifo_flush_reader_pkg.sv
// Shared constants, state encoding and pad-search helper for the nibble flush FIFO reader.
package fifo_flush_pkg;

    localparam logic [3:0] PAD_NIBBLE       = 4'hC;
    localparam int         NIBBLES_PER_WORD = 8;
    localparam int         FLUSH_HOLD       = 3;

    // F1..F3 hold the flush request for FLUSH_HOLD consecutive cycles.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_F1    = 3'd1,
        ST_F2    = 3'd2,
        ST_F3    = 3'd3,
        ST_DRAIN = 3'd4,
        ST_GAP   = 3'd5
    } reader_state_e;

    // Number of valid nibbles: index of the first pad slot, or 8 when none is present.
    function automatic logic [3:0] first_pad_index(input logic [31:0] word);
        logic [3:0] cnt;
        logic       found;
        cnt   = 4'd8;
        found = 1'b0;
        for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
            if (!found && word[4*k +: 4] == PAD_NIBBLE) begin
                cnt   = 4'(k);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fifo_flush_reader_serializer.sv
// Holds the captured flush word and replays its valid nibbles, low slot first, on a valid/ready stream.
module flush_nibble_serializer
    import fifo_flush_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic [3:0]  load_count_i,
    input  logic        active_i,
    input  logic        nib_ready_i,
    output logic        nib_valid_o,
    output logic [3:0]  nib_data_o,
    output logic        nib_last_o,
    output logic        accept_o,
    output logic        done_o
);

    logic [31:0] word_q, word_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  slot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake: a nibble transfers on a cycle where valid and ready are both high;
    // while ready is low the presented data and last flag stay unchanged.
    always_comb begin
        word_d      = word_q;
        count_d     = count_q;
        idx_d       = idx_q;
        slot        = word_q[{idx_q, 2'b00} +: 4];
        nib_valid_o = active_i;
        nib_data_o  = active_i ? slot : 4'h0;
        nib_last_o  = active_i && ({1'b0, idx_q} == (count_q - 4'd1));
        accept_o    = active_i && nib_ready_i;
        done_o      = accept_o && nib_last_o;
        if (load_i) begin
            word_d  = load_word_i;
            count_d = load_count_i;
            idx_d   = 3'd0;
        end else if (accept_o) begin
            idx_d = idx_q + 3'd1;
        end
    end

endmodule

// File: rtl/fifo_flush_reader.sv
// Read-side initiator for the nibble flush FIFO: flush handshake, word capture, nibble replay.
// Optional event counters are built when FLUSH_READER_STATS_EN is defined.
module fifo_flush_reader
    import fifo_flush_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 16,
    parameter int TO_W         = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_data_avail_i,
    input  logic        fifo_empty_i,
    input  logic [31:0] fifo_rd_data_i,
    output logic        fifo_flush_o,
    output logic        nib_valid_o,
    output logic [3:0]  nib_data_o,
    output logic        nib_last_o,
    input  logic        nib_ready_i,
    output logic        busy_o
`ifdef FLUSH_READER_STATS_EN
    ,
    output logic [15:0] stat_words_o,
    output logic [15:0] stat_nibbles_o,
    output logic [7:0]  stat_empty_o,
    output logic [7:0]  stat_timeout_o
`endif
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(IDLE_TIMEOUT);

    reader_state_e   state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            flush_q, flush_d;
    logic            start, to_start, load;
    logic [3:0]      pad_count;
    logic            accept, done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            to_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_d      = '0;
        start     = 1'b0;
        to_start  = 1'b0;
        pad_count = first_pad_index(fifo_rd_data_i);
        load      = (state_q == ST_F3);
        case (state_q)
            ST_IDLE: begin
                to_start = (IDLE_TIMEOUT != 0) && !fifo_empty_i && (to_q == TO_LIMIT);
                start    = fifo_data_avail_i || to_start;
                if (start) begin
                    state_d = ST_F1;
                end else if (!fifo_empty_i && !fifo_data_avail_i) begin
                    to_d = (to_q == TO_LIMIT) ? to_q : to_q + 1'b1;
                end
            end
            ST_F1:    state_d = ST_F2;
            ST_F2:    state_d = ST_F3;
            // An all-pad word carries no nibbles, so skip straight to the closing gap.
            ST_F3:    state_d = (pad_count != 4'd0) ? ST_DRAIN : ST_GAP;
            ST_DRAIN: state_d = done ? ST_GAP : ST_DRAIN;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        flush_d = (state_d == ST_F1) || (state_d == ST_F2) || (state_d == ST_F3);
    end

    assign fifo_flush_o = flush_q;
    assign busy_o       = (state_q != ST_IDLE);

    flush_nibble_serializer u_serializer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .load_word_i  (fifo_rd_data_i),
        .load_count_i (pad_count),
        .active_i     (state_q == ST_DRAIN),
        .nib_ready_i  (nib_ready_i),
        .nib_valid_o  (nib_valid_o),
        .nib_data_o   (nib_data_o),
        .nib_last_o   (nib_last_o),
        .accept_o     (accept),
        .done_o       (done)
    );

`ifdef FLUSH_READER_STATS_EN
    logic [15:0] words_q, words_d;
    logic [15:0] nibbles_q, nibbles_d;
    logic [7:0]  empty_q, empty_d;
    logic [7:0]  timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_q   <= '0;
            nibbles_q <= '0;
            empty_q   <= '0;
            timeout_q <= '0;
        end else begin
            words_q   <= words_d;
            nibbles_q <= nibbles_d;
            empty_q   <= empty_d;
            timeout_q <= timeout_d;
        end
    end

    // A start with data_avail high is an ordinary start even if the timeout also expired.
    always_comb begin
        words_d   = words_q + (done ? 16'd1 : 16'd0);
        nibbles_d = nibbles_q + (accept ? 16'd1 : 16'd0);
        empty_d   = empty_q + ((load && pad_count == 4'd0) ? 8'd1 : 8'd0);
        timeout_d = timeout_q + ((to_start && !fifo_data_avail_i) ? 8'd1 : 8'd0);
    end

    assign stat_words_o   = words_q;
    assign stat_nibbles_o = nibbles_q;
    assign stat_empty_o   = empty_q;
    assign stat_timeout_o = timeout_q;
`endif

endmodule
